// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: keeps a shadow copy of every instruction past Decode and
// raises load-use stalls (PC hold, IF/ID hold, ID/EX bubble) and register-file
// write-through bypass selects for sources that match the WB write.
// Optional feature macro: HAZARD_PERF_EN builds the stall-cycle and load-use
// episode counters; without it both perf ports are tied to zero.
`timescale 1ns/1ps
module hazard_scoreboard #(
    parameter int NUM_REGS   = 16,
    parameter int REG_W      = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_en,
    input  logic             id_src2_en,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             rf_bypass1,
    output logic             rf_bypass2,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_load_use
);

    // Shadow of one post-decode pipeline stage.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             wr_en;
        logic             is_load;
    } stage_t;

    // Reject parameter sets the hazard logic cannot honour.
    if (REG_W != $clog2(NUM_REGS)) begin : g_bad_reg_w
        $error("hazard_scoreboard: REG_W must equal clog2(NUM_REGS)");
    end
    if (LOAD_LAT < 1 || LOAD_LAT >= PIPE_DEPTH) begin : g_bad_load_lat
        $error("hazard_scoreboard: LOAD_LAT must satisfy 1 <= LOAD_LAT < PIPE_DEPTH");
    end

    stage_t r_stage [1:PIPE_DEPTH];   // index 1 = EX ... PIPE_DEPTH = WB
    logic   w_luse_hit;
    logic   w_luse;

    // A source hits a stage when it reads a non-zero register that stage writes.
    function automatic logic src_hit(input logic             en,
                                     input logic [REG_W-1:0] src,
                                     input stage_t           st);
        return en && (src != '0) && st.valid && st.wr_en && (st.dst == src);
    endfunction

    // Load-use detection: a source waits on a load still inside its latency window.
    always_comb begin
        // NOTE: default assigned first so no path through the loop leaves w_luse_hit unassigned (no latch).
        w_luse_hit = 1'b0;
        for (int k = 1; k <= LOAD_LAT; k++) begin
            if (r_stage[k].is_load &&
                (src_hit(id_src1_en, id_src1, r_stage[k]) ||
                 src_hit(id_src2_en, id_src2, r_stage[k]))) begin
                w_luse_hit = 1'b1;
            end
        end
    end

    // A squashed or empty Decode slot can never stall.
    assign w_luse = id_valid && !flush && w_luse_hit;

    // Stall/bubble priority: memory freeze beats load-use; reset silences everything.
    assign pc_stall     = !rst && (mem_stall || w_luse);
    assign if_id_stall  = pc_stall;
    assign id_ex_bubble = !rst && !mem_stall && w_luse;
    assign rf_bypass1   = !rst && src_hit(id_src1_en, id_src1, r_stage[PIPE_DEPTH]);
    assign rf_bypass2   = !rst && src_hit(id_src2_en, id_src2, r_stage[PIPE_DEPTH]);

    // Shadow pipeline advance: shift one stage per unfrozen cycle, bubble on stall/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits are reset; payload fields are ignored while a stage is invalid.
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                r_stage[k].valid <= 1'b0;
            end
        end else if (!mem_stall) begin
            // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
            r_stage[1] <= '{valid:   id_valid && !flush && !w_luse,
                            dst:     id_dst,
                            wr_en:   id_wr_en,
                            is_load: id_is_load};
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic        r_luse_d;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_luse;

    // Saturating counters: stall cycles outside freezes, and rising edges of load-use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_luse_d     <= 1'b0;
            r_perf_stall <= '0;
            r_perf_luse  <= '0;
        end else begin
            r_luse_d <= w_luse;
            if (w_luse && !mem_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_luse && !r_luse_d && (r_perf_luse != '1)) begin
                r_perf_luse <= r_perf_luse + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = rst ? 32'd0 : r_perf_stall;
    assign perf_load_use     = rst ? 32'd0 : r_perf_luse;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_load_use     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: two instances (defaults, and PIPE_DEPTH=4 /
// LOAD_LAT=2) share one Decode stream; directed scenarios plus a randomized run
// against an age-indexed in-flight instruction model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_src1_en, id_src2_en, id_wr_en, id_is_load, mem_stall, flush;
    logic [3:0] id_src1, id_src2, id_dst;

    logic        a_pc, a_ifid, a_bub, a_b1, a_b2;
    logic        b_pc, b_ifid, b_bub, b_b1, b_b2;
    logic [31:0] a_pst, a_plu, b_pst, b_plu;
    logic [4:0]  fa, fb;
    assign fa = {a_pc, a_ifid, a_bub, a_b1, a_b2};
    assign fb = {b_pc, b_ifid, b_bub, b_b1, b_b2};

    hazard_scoreboard u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .mem_stall(mem_stall), .flush(flush),
        .pc_stall(a_pc), .if_id_stall(a_ifid), .id_ex_bubble(a_bub),
        .rf_bypass1(a_b1), .rf_bypass2(a_b2),
        .perf_stall_cycles(a_pst), .perf_load_use(a_plu)
    );

    hazard_scoreboard #(.PIPE_DEPTH(4), .LOAD_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .mem_stall(mem_stall), .flush(flush),
        .pc_stall(b_pc), .if_id_stall(b_ifid), .id_ex_bubble(b_bub),
        .rf_bypass1(b_b1), .rf_bypass2(b_b2),
        .perf_stall_cycles(b_pst), .perf_load_use(b_plu)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per instance, instructions by age after Decode (age 0 = EX).
    typedef struct { bit v; bit [3:0] d; bit w; bit l; } ent_t;
    ent_t        m_pipe [2][4];
    int unsigned m_st [2];
    int unsigned m_lu [2];
    bit          m_prev [2];

    function automatic int m_depth(int i); return (i == 0) ? 3 : 4; endfunction
    function automatic int m_lat(int i);   return (i == 0) ? 1 : 2; endfunction

    function automatic bit m_reads(int i, int age, bit en, bit [3:0] src);
        return en && (src != 4'd0) && m_pipe[i][age].v && m_pipe[i][age].w && (m_pipe[i][age].d == src);
    endfunction

    function automatic bit m_luse(int i);
        bit hit = 1'b0;
        for (int a = 0; a < m_lat(i); a++)
            if (m_pipe[i][a].l && (m_reads(i, a, id_src1_en, id_src1) || m_reads(i, a, id_src2_en, id_src2)))
                hit = 1'b1;
        return id_valid && !flush && hit;
    endfunction

    function automatic logic [4:0] m_flags(int i);
        bit lu = m_luse(i);
        if (rst) return 5'b0;
        return {mem_stall || lu, mem_stall || lu, !mem_stall && lu,
                m_reads(i, m_depth(i) - 1, id_src1_en, id_src1),
                m_reads(i, m_depth(i) - 1, id_src2_en, id_src2)};
    endfunction

    task automatic m_clock();
        for (int i = 0; i < 2; i++) begin
            bit lu;
            lu = m_luse(i);
            if (rst) begin
                for (int a = 0; a < 4; a++) m_pipe[i][a].v = 1'b0;
                m_st[i] = 0; m_lu[i] = 0; m_prev[i] = 1'b0;
            end else begin
                if (lu && !mem_stall) m_st[i]++;
                if (lu && !m_prev[i]) m_lu[i]++;
                m_prev[i] = lu;
                if (!mem_stall) begin
                    for (int a = 3; a > 0; a--) m_pipe[i][a] = m_pipe[i][a-1];
                    m_pipe[i][0] = '{v: id_valid && !flush && !lu, d: id_dst, w: id_wr_en, l: id_is_load};
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic set_id(bit v, bit [3:0] s1, bit e1, bit [3:0] s2, bit e2, bit [3:0] d, bit w, bit l);
        id_valid = v; id_src1 = s1; id_src1_en = e1; id_src2 = s2; id_src2_en = e2;
        id_dst = d; id_wr_en = w; id_is_load = l;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        mem_stall = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; mem_stall = 1; flush = 0;
        set_id(1, 3, 1, 3, 1, 3, 1, 1);
        tick(); #1;
        n_cmp++; if ({fa, fb} !== 10'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", {fa, fb}, 10'b0); end
        n_cmp++; if ({a_pst, a_plu, b_pst, b_plu} !== 128'b0) begin n_bad++; $display("FAIL reset_perf_in_rst: got %h expected 0", {a_pst, a_plu, b_pst, b_plu}); end
        idle(); tick(); rst = 0; #1;
        n_cmp++; if ({fa, fb} !== 10'b0) begin n_bad++; $display("FAIL reset_idle_flags: got %b expected %b", {fa, fb}, 10'b0); end
        n_cmp++; if ({a_pst, a_plu, b_pst, b_plu} !== 128'b0) begin n_bad++; $display("FAIL reset_perf_cleared: got %h expected 0", {a_pst, a_plu, b_pst, b_plu}); end
    endtask

    task automatic test_load_use();
        int na = 0, nb = 0;
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1); #1;                      // LW r3
        n_cmp++; if ({fa, fb} !== 10'b0) begin n_bad++; $display("FAIL lu_issue: got %b expected %b", {fa, fb}, 10'b0); end
        tick();
        set_id(1, 3, 1, 4, 1, 5, 1, 0);                           // ADD r5,r3,r4 held
        for (int c = 0; c < 3; c++) begin #1; na += int'(a_bub); nb += int'(b_bub); tick(); end
        n_cmp++; if (na != 1) begin n_bad++; $display("FAIL lu_len_a: got %0d expected %0d", na, 1); end
        n_cmp++; if (nb != 2) begin n_bad++; $display("FAIL lu_len_b: got %0d expected %0d", nb, 2); end
        n_cmp++; if ({a_pst, a_plu} !== {32'(PERF), 32'(PERF)}) begin n_bad++; $display("FAIL lu_perf_a: got %0d/%0d expected %0d/%0d", a_pst, a_plu, PERF, PERF); end
        n_cmp++; if ({b_pst, b_plu} !== {32'(2*PERF), 32'(PERF)}) begin n_bad++; $display("FAIL lu_perf_b: got %0d/%0d expected %0d/%0d", b_pst, b_plu, 2*PERF, PERF); end
    endtask

    task automatic test_independent_gap();
        int na = 0, nb = 0;
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();                  // LW r3
        set_id(1, 1, 1, 2, 1, 9, 1, 0); tick();                  // ADD r9,r1,r2
        set_id(1, 3, 1, 4, 1, 5, 1, 0);                           // ADD r5,r3,r4 held
        for (int c = 0; c < 3; c++) begin #1; na += int'(a_bub); nb += int'(b_bub); tick(); end
        n_cmp++; if (na != 0) begin n_bad++; $display("FAIL gap_len_a: got %0d expected %0d", na, 0); end
        n_cmp++; if (nb != 1) begin n_bad++; $display("FAIL gap_len_b: got %0d expected %0d", nb, 1); end
    endtask

    task automatic test_zero_and_nonload();
        logic [5:0] acc = '0;
        logic [1:0] acc2 = '0;
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();                  // LW r0
        set_id(1, 0, 1, 0, 1, 1, 1, 0);                           // ADD r1,r0,r0
        for (int c = 0; c < 3; c++) begin #1; acc |= {a_pc, b_pc, a_b1, a_b2, b_b1, b_b2}; tick(); end
        n_cmp++; if (acc !== 6'b0) begin n_bad++; $display("FAIL zero_reg: got %b expected %b", acc, 6'b0); end
        set_id(1, 1, 1, 2, 1, 3, 1, 0); tick();                  // ADD r3 (not a load)
        set_id(1, 3, 1, 3, 1, 6, 1, 0);                           // SUB r6,r3,r3
        for (int c = 0; c < 2; c++) begin #1; acc2 |= {a_pc, b_pc}; tick(); end
        n_cmp++; if (acc2 !== 2'b0) begin n_bad++; $display("FAIL nonload_nostall: got %b expected %b", acc2, 2'b0); end
    endtask

    task automatic test_mem_freeze();
        logic [5:0] bub_a, pc_a, bub_b, pc_b;
        logic [63:0] mid;
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();                  // LW r3
        set_id(1, 3, 1, 4, 1, 5, 1, 0);                           // dependent ADD held
        for (int c = 0; c < 6; c++) begin
            mem_stall = (c < 3); #1;
            bub_a[c] = a_bub; pc_a[c] = a_pc; bub_b[c] = b_bub; pc_b[c] = b_pc;
            if (c == 2) mid = {a_pst, b_pst};
            tick();
        end
        mem_stall = 0;
        n_cmp++; if (bub_a !== 6'b001000) begin n_bad++; $display("FAIL freeze_bub_a: got %b expected %b", bub_a, 6'b001000); end
        n_cmp++; if (pc_a !== 6'b001111) begin n_bad++; $display("FAIL freeze_pc_a: got %b expected %b", pc_a, 6'b001111); end
        n_cmp++; if (bub_b !== 6'b011000) begin n_bad++; $display("FAIL freeze_bub_b: got %b expected %b", bub_b, 6'b011000); end
        n_cmp++; if (pc_b !== 6'b011111) begin n_bad++; $display("FAIL freeze_pc_b: got %b expected %b", pc_b, 6'b011111); end
        n_cmp++; if (mid !== 64'b0) begin n_bad++; $display("FAIL freeze_perf_mid: got %h expected 0", mid); end
        n_cmp++; if ({a_pst, a_plu, b_pst, b_plu} !== {32'(PERF), 32'(PERF), 32'(2*PERF), 32'(PERF)})
            begin n_bad++; $display("FAIL freeze_perf_end: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                                    a_pst, a_plu, b_pst, b_plu, PERF, PERF, 2*PERF, PERF); end
    endtask

    task automatic test_bypass();
        do_reset();
        set_id(1, 1, 1, 2, 1, 7, 1, 0); tick();                  // ADD r7
        idle(); tick(); tick();
        set_id(1, 2, 1, 7, 1, 8, 1, 0); #1;                      // reads r2, r7
        n_cmp++; if ({a_b1, a_b2, a_pc} !== 3'b010) begin n_bad++; $display("FAIL bypass_a_wb: got %b expected %b", {a_b1, a_b2, a_pc}, 3'b010); end
        n_cmp++; if ({b_b1, b_b2} !== 2'b00) begin n_bad++; $display("FAIL bypass_b_early: got %b expected %b", {b_b1, b_b2}, 2'b00); end
        tick(); #1;
        n_cmp++; if ({b_b1, b_b2} !== 2'b01) begin n_bad++; $display("FAIL bypass_b_wb: got %b expected %b", {b_b1, b_b2}, 2'b01); end
        n_cmp++; if ({a_b1, a_b2} !== 2'b00) begin n_bad++; $display("FAIL bypass_a_retired: got %b expected %b", {a_b1, a_b2}, 2'b00); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();                  // LW r3
        set_id(1, 3, 1, 0, 0, 5, 1, 1); flush = 1; #1;           // LW r5 <- r3, squashed
        n_cmp++; if ({fa, fb} !== 10'b0) begin n_bad++; $display("FAIL flush_nostall: got %b expected %b", {fa, fb}, 10'b0); end
        tick(); flush = 0;
        set_id(1, 5, 1, 0, 0, 6, 1, 0); #1;                      // reads r5
        n_cmp++; if ({a_pc, b_pc} !== 2'b00) begin n_bad++; $display("FAIL flush_not_entered: got %b expected %b", {a_pc, b_pc}, 2'b00); end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 1, 4, 1, 5, 1, 0); #1;
        n_cmp++; if ({a_bub, b_bub} !== 2'b11) begin n_bad++; $display("FAIL rst_pre_stall: got %b expected %b", {a_bub, b_bub}, 2'b11); end
        tick(); rst = 1; #1;
        n_cmp++; if ({fa, fb} !== 10'b0) begin n_bad++; $display("FAIL rst_during: got %b expected %b", {fa, fb}, 10'b0); end
        tick(); rst = 0; #1;
        n_cmp++; if ({fa, fb} !== 10'b0) begin n_bad++; $display("FAIL rst_after: got %b expected %b", {fa, fb}, 10'b0); end
        n_cmp++; if ({a_pst, a_plu, b_pst, b_plu} !== 128'b0) begin n_bad++; $display("FAIL rst_after_perf: got %h expected 0", {a_pst, a_plu, b_pst, b_plu}); end
    endtask

    task automatic test_random();
        logic [127:0] exp_perf;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            mem_stall = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 7) != 0,
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)));
            #1;
            exp_perf = rst ? 128'b0 : {32'(PERF * m_st[0]), 32'(PERF * m_lu[0]), 32'(PERF * m_st[1]), 32'(PERF * m_lu[1])};
            n_cmp++; if (fa !== m_flags(0)) begin n_bad++; $display("FAIL rand_flags_a cyc %0d: got %b expected %b", c, fa, m_flags(0)); end
            n_cmp++; if (fb !== m_flags(1)) begin n_bad++; $display("FAIL rand_flags_b cyc %0d: got %b expected %b", c, fb, m_flags(1)); end
            n_cmp++; if ({a_pst, a_plu, b_pst, b_plu} !== exp_perf) begin n_bad++; $display("FAIL rand_perf cyc %0d: got %h expected %h", c, {a_pst, a_plu, b_pst, b_plu}, exp_perf); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_independent_gap();
        test_zero_and_nonload();
        test_mem_freeze();
        test_bypass();
        test_flush();
        test_rst_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor of the pipeline hazard detector: it tracks its own shadow copy of every in-flight instruction after Decode and generates load-use stalls and register-file bypass selects.
- Supports configurable register count, post-decode pipeline depth and load latency (multi-cycle memory), plus a data-memory freeze and a decode flush.
- Sits beside the IF/ID and ID/EX pipeline registers; its outputs drive PC hold, IF/ID hold and ID/EX bubble insertion.

Parameters:
- NUM_REGS, 16, architectural register count; register 0 is hard-wired zero and never causes a hazard.
- REG_W, 4, register index width; must equal clog2(NUM_REGS).
- PIPE_DEPTH, 3, number of shadow stages after ID (1=EX, 2=MEM, ..., PIPE_DEPTH=WB).
- LOAD_LAT, 1, number of shadow stages (1..LOAD_LAT) in which a load result is not yet forwardable; legal range 1 <= LOAD_LAT < PIPE_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  Decode holds a real instruction.
- id_src1, id_src2  in  REG_W  source register indices.
- id_src1_en, id_src2_en  in  1  the corresponding source is actually read.
- id_dst  in  REG_W  destination register index.
- id_wr_en  in  1  instruction writes id_dst.
- id_is_load  in  1  instruction is LW.
- mem_stall  in  1  data memory busy; freezes the entire pipeline.
- flush  in  1  squashes the Decode instruction (taken branch).
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- rf_bypass1, rf_bypass2  out  1  source matches the WB write this cycle; the register file read port returns the write data.
- perf_stall_cycles  out  32  see Optional Feature.
- perf_load_use  out  32  see Optional Feature.

Behaviour:
- Shadow stage k (1..PIPE_DEPTH) holds {valid, dst, wr_en, is_load}.
- Reset: all stages invalid, perf counters 0. While rst=1 all outputs are forced to 0.
- src_hit(s, k): en_s & src_s != 0 & stage k valid & wr_en & dst == src_s.
- luse (combinational) = id_valid & !flush & OR over s and k in 1..LOAD_LAT of (src_hit(s, k) & is_load).
- Non-load producers never stall; forwarding is handled by the EX forwarding unit.
- Output priority:
  - mem_stall=1: pc_stall=1, if_id_stall=1, id_ex_bubble=0, shadow stages hold.
  - else luse=1: pc_stall=1, if_id_stall=1, id_ex_bubble=1.
  - else all three outputs are 0.
- Shadow update on the edge when mem_stall=0:
  - Stage 1 loads the Decode fields if id_valid & !flush & !luse; otherwise stage 1 becomes invalid (bubble).
  - Stage k loads stage k-1 for k >= 2.
  - The WB entry retires.
- Stall length: a load-use pair adjacent in program order stalls exactly LOAD_LAT cycles; with one independent instruction between them it stalls LOAD_LAT-1 cycles.
- mem_stall during a load-use stall: everything freezes; the stall resumes with its remaining count unchanged.
- rf_bypass_s = src_hit(s, PIPE_DEPTH). It is valid regardless of stalls and is 0 when src = 0.
- Both sources hitting the same load: a single stall sequence, not doubled.
- flush together with luse: no stall, and the flushed instruction is not entered.
- rst mid-stall: next cycle pipeline empty, no stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cycles increments on every cycle with luse=1 and mem_stall=0.
  - perf_load_use increments once per distinct stall episode, on the first cycle luse rises.
  - Both counters saturate at all-ones and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Defaults: LW r3 issued, next instr ADD r5,r3,r4 in ID -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then ADD proceeds; perf_load_use=1, perf_stall_cycles=1.
- LOAD_LAT=2, PIPE_DEPTH=4: LW r3 then dependent ADD -> exactly 2 stall cycles. Same with an independent instr between them -> exactly 1 stall cycle.
- LW r0 then ADD r1,r0,r0 -> no stall, rf_bypass=0. ADD r3 (non-load) then SUB r6,r3,r3 -> no stall.
- mem_stall=1 for 3 cycles arriving during a load-use stall -> bubble=0 during the freeze; after release exactly the remaining stall cycle occurs, and perf_stall_cycles is unchanged by the freeze.
- Producer r7 reaches the WB stage while ID reads r7 on src2 -> rf_bypass2=1, rf_bypass1=0.
- flush=1 with a load-use match -> all stall outputs 0, and stage 1 is invalid next cycle. Assert rst during a stall -> all outputs 0 the following cycle.
